// File: rtl/mips_pipe_core.sv
// Five-stage MIPS32-subset integer core (IF/ID/EX/MEM/WB) with optional operand forwarding,
// load-use / interlock stalls, EX-resolved branch flush and a retired-instruction counter.
module mips_pipe_core #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 10,
    parameter bit          FORWARD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic              dmem_we,
    output logic              halted,
    output logic [XLEN-1:0]   instret
);

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAnd   = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b000011;
    localparam logic [5:0] OpSlt   = 6'b000100;
    localparam logic [5:0] OpMul   = 6'b000101;
    localparam logic [5:0] OpLw    = 6'b001000;
    localparam logic [5:0] OpSw    = 6'b001001;
    localparam logic [5:0] OpAddi  = 6'b001010;
    localparam logic [5:0] OpSubi  = 6'b001011;
    localparam logic [5:0] OpSlti  = 6'b001100;
    localparam logic [5:0] OpBneqz = 6'b001101;
    localparam logic [5:0] OpBeqz  = 6'b001110;
    localparam logic [5:0] OpHlt   = 6'b111111;

    localparam logic [ADDR_W-1:0] PcOne   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]   XlenOne = {{(XLEN-1){1'b0}}, 1'b1};

    // Architectural and pipeline state
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              stop_fetch_q, stop_fetch_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   instret_q, instret_d;
    logic [XLEN-1:0]   rf_q [32];
    logic [XLEN-1:0]   rf_d [32];

    logic              ifid_valid_q, ifid_valid_d;
    logic [31:0]       ifid_ir_q, ifid_ir_d;
    logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;

    logic              idex_valid_q, idex_valid_d;
    logic [5:0]        idex_op_q, idex_op_d;
    logic [4:0]        idex_rs_q, idex_rs_d;
    logic [4:0]        idex_rt_q, idex_rt_d;
    logic [4:0]        idex_dest_q, idex_dest_d;
    logic              idex_we_q, idex_we_d;
    logic [XLEN-1:0]   idex_a_q, idex_a_d;
    logic [XLEN-1:0]   idex_b_q, idex_b_d;
    logic [XLEN-1:0]   idex_imm_q, idex_imm_d;
    logic [ADDR_W-1:0] idex_pc_q, idex_pc_d;

    logic              exmem_valid_q, exmem_valid_d;
    logic [5:0]        exmem_op_q, exmem_op_d;
    logic [4:0]        exmem_dest_q, exmem_dest_d;
    logic              exmem_we_q, exmem_we_d;
    logic [XLEN-1:0]   exmem_res_q, exmem_res_d;
    logic [XLEN-1:0]   exmem_sd_q, exmem_sd_d;

    logic              memwb_valid_q, memwb_valid_d;
    logic              memwb_hlt_q, memwb_hlt_d;
    logic [4:0]        memwb_dest_q, memwb_dest_d;
    logic              memwb_we_q, memwb_we_d;
    logic [XLEN-1:0]   memwb_res_q, memwb_res_d;

    // ID decode and hazard detection
    logic [5:0]      id_op;
    logic [4:0]      id_rs, id_rt, id_dest;
    logic [XLEN-1:0] id_imm, id_a, id_b;
    logic            id_is_rr, id_is_rm, id_is_br, id_is_hlt;
    logic            id_use_rs, id_use_rt, id_we;
    logic            hit_ex, hit_mem, stall, wb_wr;

    assign wb_wr = memwb_valid_q && memwb_we_q;

    always_comb begin
        id_op     = ifid_ir_q[31:26];
        id_rs     = ifid_ir_q[25:21];
        id_rt     = ifid_ir_q[20:16];
        id_imm    = {XLEN{ifid_ir_q[15]}};
        id_imm[15:0] = ifid_ir_q[15:0];
        id_is_rr  = (id_op[5:3] == 3'b000) && (id_op[2:0] <= 3'd5);
        id_is_rm  = (id_op == OpAddi) || (id_op == OpSubi) || (id_op == OpSlti);
        id_is_br  = (id_op == OpBneqz) || (id_op == OpBeqz);
        id_is_hlt = ifid_valid_q && (id_op == OpHlt);
        id_use_rs = id_is_rr || id_is_rm || id_is_br || (id_op == OpLw) || (id_op == OpSw);
        id_use_rt = id_is_rr || (id_op == OpSw);
        id_dest   = id_is_rr ? ifid_ir_q[15:11] : id_rt;
        // r0 destinations are dropped here so they can never match a forward or hazard
        id_we     = (id_is_rr || id_is_rm || (id_op == OpLw)) && (id_dest != 5'd0);

        id_a = rf_q[id_rs];
        if (wb_wr && (memwb_dest_q == id_rs)) id_a = memwb_res_q;
        id_b = rf_q[id_rt];
        if (wb_wr && (memwb_dest_q == id_rt)) id_b = memwb_res_q;

        hit_ex  = idex_valid_q && idex_we_q &&
                  ((id_use_rs && (id_rs == idex_dest_q)) || (id_use_rt && (id_rt == idex_dest_q)));
        hit_mem = exmem_valid_q && exmem_we_q &&
                  ((id_use_rs && (id_rs == exmem_dest_q)) || (id_use_rt && (id_rt == exmem_dest_q)));
        if (FORWARD_EN) stall = ifid_valid_q && hit_ex && (idex_op_q == OpLw);
        else            stall = ifid_valid_q && (hit_ex || hit_mem);
    end

    // EX: operand forwarding, ALU, branch resolution
    logic [XLEN-1:0]   ex_a, ex_b, ex_res;
    logic              ex_taken, fwd_mem_ok;
    logic [ADDR_W-1:0] ex_target;

    assign fwd_mem_ok = exmem_valid_q && exmem_we_q && (exmem_op_q != OpLw);

    always_comb begin
        ex_a = idex_a_q;
        ex_b = idex_b_q;
        if (FORWARD_EN) begin
            if (fwd_mem_ok && (exmem_dest_q == idex_rs_q))  ex_a = exmem_res_q;
            else if (wb_wr && (memwb_dest_q == idex_rs_q)) ex_a = memwb_res_q;
            if (fwd_mem_ok && (exmem_dest_q == idex_rt_q))  ex_b = exmem_res_q;
            else if (wb_wr && (memwb_dest_q == idex_rt_q)) ex_b = memwb_res_q;
        end

        ex_res = '0;
        case (idex_op_q)
            OpAdd:             ex_res = ex_a + ex_b;
            OpSub:             ex_res = ex_a - ex_b;
            OpAnd:             ex_res = ex_a & ex_b;
            OpOr:              ex_res = ex_a | ex_b;
            OpSlt:             ex_res[0] = $signed(ex_a) < $signed(ex_b);
            OpMul:             ex_res = ex_a * ex_b;
            OpAddi, OpLw, OpSw: ex_res = ex_a + idex_imm_q;
            OpSubi:            ex_res = ex_a - idex_imm_q;
            OpSlti:            ex_res[0] = $signed(ex_a) < $signed(idex_imm_q);
            default:           ex_res = '0;
        endcase

        ex_taken  = idex_valid_q && (((idex_op_q == OpBeqz) && (ex_a == '0)) ||
                                     ((idex_op_q == OpBneqz) && (ex_a != '0)));
        ex_target = idex_pc_q + PcOne + idex_imm_q[ADDR_W-1:0];
    end

    // MEM and external interfaces
    logic [XLEN-1:0] mem_res;

    assign mem_res    = (exmem_op_q == OpLw) ? dmem_rdata : exmem_res_q;
    assign imem_addr  = pc_q;
    assign dmem_addr  = exmem_res_q[ADDR_W-1:0];
    assign dmem_wdata = exmem_sd_q;
    assign dmem_we    = exmem_valid_q && (exmem_op_q == OpSw) && !halted_q;
    assign halted     = halted_q;
    assign instret    = instret_q;

    // Next-state; everything holds once halted
    always_comb begin
        pc_d = pc_q;  stop_fetch_d = stop_fetch_q;  halted_d = halted_q;  instret_d = instret_q;
        rf_d = rf_q;
        ifid_valid_d = ifid_valid_q;  ifid_ir_d = ifid_ir_q;  ifid_pc_d = ifid_pc_q;
        idex_valid_d = idex_valid_q;  idex_op_d = idex_op_q;  idex_rs_d = idex_rs_q;
        idex_rt_d = idex_rt_q;  idex_dest_d = idex_dest_q;  idex_we_d = idex_we_q;
        idex_a_d = idex_a_q;  idex_b_d = idex_b_q;  idex_imm_d = idex_imm_q;  idex_pc_d = idex_pc_q;
        exmem_valid_d = exmem_valid_q;  exmem_op_d = exmem_op_q;  exmem_dest_d = exmem_dest_q;
        exmem_we_d = exmem_we_q;  exmem_res_d = exmem_res_q;  exmem_sd_d = exmem_sd_q;
        memwb_valid_d = memwb_valid_q;  memwb_hlt_d = memwb_hlt_q;  memwb_dest_d = memwb_dest_q;
        memwb_we_d = memwb_we_q;  memwb_res_d = memwb_res_q;

        if (!halted_q) begin
            if (memwb_valid_q) begin
                if (memwb_hlt_q) halted_d = 1'b1;
                else             instret_d = instret_q + XlenOne;
            end
            if (wb_wr) rf_d[memwb_dest_q] = memwb_res_q;

            memwb_valid_d = exmem_valid_q;
            memwb_hlt_d   = exmem_op_q == OpHlt;
            memwb_dest_d  = exmem_dest_q;
            memwb_we_d    = exmem_we_q;
            memwb_res_d   = mem_res;

            exmem_valid_d = idex_valid_q;
            exmem_op_d    = idex_op_q;
            exmem_dest_d  = idex_dest_q;
            exmem_we_d    = idex_we_q;
            exmem_res_d   = ex_res;
            exmem_sd_d    = ex_b;

            idex_valid_d = ifid_valid_q && !stall && !ex_taken;
            idex_op_d    = id_op;
            idex_rs_d    = id_rs;
            idex_rt_d    = id_rt;
            idex_dest_d  = id_dest;
            idex_we_d    = id_we;
            idex_a_d     = id_a;
            idex_b_d     = id_b;
            idex_imm_d   = id_imm;
            idex_pc_d    = ifid_pc_q;

            // A taken branch wins over both stall and a younger HLT
            if (ex_taken) begin
                pc_d         = ex_target;
                ifid_valid_d = 1'b0;
            end else if (!stall) begin
                if (id_is_hlt || stop_fetch_q) begin
                    stop_fetch_d = 1'b1;
                    ifid_valid_d = 1'b0;
                end else begin
                    pc_d         = pc_q + PcOne;
                    ifid_valid_d = 1'b1;
                    ifid_ir_d    = imem_rdata;
                    ifid_pc_d    = pc_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;  stop_fetch_q <= 1'b0;  halted_q <= 1'b0;  instret_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
            ifid_valid_q <= 1'b0;  ifid_ir_q <= '0;  ifid_pc_q <= '0;
            idex_valid_q <= 1'b0;  idex_op_q <= '0;  idex_rs_q <= '0;  idex_rt_q <= '0;
            idex_dest_q <= '0;  idex_we_q <= 1'b0;  idex_a_q <= '0;  idex_b_q <= '0;
            idex_imm_q <= '0;  idex_pc_q <= '0;
            exmem_valid_q <= 1'b0;  exmem_op_q <= '0;  exmem_dest_q <= '0;  exmem_we_q <= 1'b0;
            exmem_res_q <= '0;  exmem_sd_q <= '0;
            memwb_valid_q <= 1'b0;  memwb_hlt_q <= 1'b0;  memwb_dest_q <= '0;
            memwb_we_q <= 1'b0;  memwb_res_q <= '0;
        end else begin
            pc_q <= pc_d;  stop_fetch_q <= stop_fetch_d;  halted_q <= halted_d;
            instret_q <= instret_d;
            for (int i = 0; i < 32; i++) rf_q[i] <= rf_d[i];
            ifid_valid_q <= ifid_valid_d;  ifid_ir_q <= ifid_ir_d;  ifid_pc_q <= ifid_pc_d;
            idex_valid_q <= idex_valid_d;  idex_op_q <= idex_op_d;  idex_rs_q <= idex_rs_d;
            idex_rt_q <= idex_rt_d;  idex_dest_q <= idex_dest_d;  idex_we_q <= idex_we_d;
            idex_a_q <= idex_a_d;  idex_b_q <= idex_b_d;  idex_imm_q <= idex_imm_d;
            idex_pc_q <= idex_pc_d;
            exmem_valid_q <= exmem_valid_d;  exmem_op_q <= exmem_op_d;
            exmem_dest_q <= exmem_dest_d;  exmem_we_q <= exmem_we_d;
            exmem_res_q <= exmem_res_d;  exmem_sd_q <= exmem_sd_d;
            memwb_valid_q <= memwb_valid_d;  memwb_hlt_q <= memwb_hlt_d;
            memwb_dest_q <= memwb_dest_d;  memwb_we_q <= memwb_we_d;  memwb_res_q <= memwb_res_d;
        end
    end

endmodule

// File: doc/mips_pipe_core.md
Name: mips_pipe_core

Overview:
- Next-generation, parametrised 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset integer core running on a single clock.
- Adds the following:
  - full EX/MEM and MEM/WB operand forwarding, selectable by a mode parameter;
  - load-use hazard stall;
  - branch flush with no software NOPs needed;
  - write-first register file;
  - retired-instruction counter.
- Instruction and data memories are external. Reads are combinational; data-memory writes are synchronous.

Parameters:
- XLEN, 32, datapath and register width (>=16; immediate sign-extended to XLEN).
- ADDR_W, 10, word address width of instruction and data memories.
- FORWARD_EN, 1, 1 = forwarding plus load-use stall; 0 = no forwarding, interlock until producer reaches WB.

Ports:
- clk, in, 1, core clock; all state updates on posedge.
- rst_n, in, 1, asynchronous active-low reset.
- imem_addr, out, ADDR_W, fetch word address (= PC).
- imem_rdata, in, 32, instruction at imem_addr, same cycle.
- dmem_addr, out, ADDR_W, data word address (EX/MEM ALU result, low ADDR_W bits).
- dmem_rdata, in, XLEN, load data at dmem_addr, same cycle.
- dmem_wdata, out, XLEN, store data.
- dmem_we, out, 1, store strobe; memory writes on posedge when high.
- halted, out, 1, high once HLT has retired; sticky until reset.
- instret, out, XLEN, count of retired non-HLT instructions; wraps modulo 2^XLEN.

Behaviour:
- Reset (async assert, sync release):
  - PC=0; all stage valid bits=0 (bubbles); register file all 0.
  - halted=0, instret=0, dmem_we=0.
- ISA, opcode[31:26]:
  - ADD 000000, SUB 000001, AND 000010, OR 000011, SLT 000100, MUL 000101.
  - LW 001000, SW 001001, ADDI 001010, SUBI 001011, SLTI 001100.
  - BNEQZ 001101, BEQZ 001110, HLT 111111.
  - Any other opcode = NOP: flows through, no writes, counted in instret.
- Fields: rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0] sign-extended to XLEN.
- Results and addresses:
  - RR writes rd; RM and LW write rt. r0 is hardwired 0; writes to r0 are discarded and never forwarded.
  - SLT/SLTI use a signed compare; result is 1 or 0.
  - MUL keeps the low XLEN bits; add/sub wrap.
  - LW/SW address = rs+imm, truncated to ADDR_W. SW stores rt.
- Latency: an instruction fetched in cycle N writes back in the cycle-N+4 edge. Throughput is 1 IPC without hazards.
- Register file is write-first: a WB write in cycle C is visible to an ID read in cycle C.
- Forwarding (FORWARD_EN=1):
  - EX operand priority: EX/MEM result (non-load) > MEM/WB result or load data > ID/EX value.
  - Load-use: if the instruction in ID sources the destination of a valid LW in EX, PC and IF/ID hold for 1 cycle and a bubble enters EX.
- FORWARD_EN=0: ID stalls while any source matches a valid destination in EX or MEM.
- Sources by class:
  - RR: rs, rt. RM: rs. LW: rs. SW: rs, rt. Branch: rs.
- Branch resolution:
  - Resolved in EX; target = PC_of_branch+1+imm.
  - Taken when BEQZ with rs==0, or BNEQZ with rs!=0; operand is forwarded.
  - If taken, the next edge loads PC=target and invalidates IF/ID and ID/EX (2-cycle penalty).
  - A stall request in the same cycle is overridden by the flush.
- Halt:
  - HLT in ID freezes PC and bubbles IF/ID. HLT continues down the pipe; older instructions complete.
  - When HLT reaches WB, halted=1 and all state freezes; dmem_we=0 thereafter.
  - An HLT flushed by a taken branch has no effect.
- dmem_we is high only for a valid SW in MEM.

Test Plan:
- Forwarding: ADDI r1,r0,10; ADDI r2,r0,20; ADD r3,r1,r2; HLT -> r3=30, halted after 8 cycles, instret=3, zero stall cycles.
- Load-use: dmem[5]=7; ADDI r1,r0,5; LW r2,0(r1); ADD r3,r2,r2; HLT -> exactly 1 stall cycle, r3=14.
- Branch flush: ADDI r1,r0,0; BEQZ r1,+2; ADDI r4,r0,1; ADDI r4,r0,2; ADDI r5,r0,3; HLT -> r4=0, r5=3, the two flushed slots leave no writes.
- FORWARD_EN=0 rerun of the first scenario -> same results, stall cycles observed, cycle count strictly greater.
- Signed/edge: ADDI r1,r0,-1; SLTI r2,r1,0; ADDI r0,r0,9; SW r1,3(r0) -> r2=1, r0=0, dmem[3]=all-ones, dmem_we pulses for one cycle.
- rst_n asserted mid-loop -> outputs return to reset values immediately; execution restarts from PC=0.
